// File: rtl/ks_serial_adder.sv
// ---------------------------------------------------------------------------
// ks_serial_adder
//   Multi-cycle wide adder. Two WIDTH-bit operands and a carry-in are captured
//   on a start pulse and then pushed through a single 4-bit Kogge-Stone slice,
//   one nibble per clock, LSB nibble first. The inter-nibble carry is held in
//   a register. When the last nibble is done, the full sum and the final
//   carry-out are registered and done pulses for one cycle.
//
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   synchronous active-high reset
//     start in   operation request (ignored while busy)
//     A, B  in   WIDTH-bit unsigned operands, latched with start
//     cin   in   carry-in, latched with start
//     busy  out  high while nibbles are being processed
//     done  out  one-cycle pulse, sum/cout valid
//     sum   out  registered result (partial while busy)
//     cout  out  registered final carry-out
//
//   Also contains kogge_stone_4bit, the combinational 4-bit prefix adder slice.
// ---------------------------------------------------------------------------

// 4-bit Kogge-Stone adder slice. Ports: A[4:1], B[4:1], cin -> sum[4:1], cout.
module kogge_stone_4bit (
  input  logic [4:1] A,
  input  logic [4:1] B,
  input  logic       cin,
  output logic [4:1] sum,
  output logic       cout
);
  logic [4:1] g0;
  logic [4:1] p0;
  logic [4:1] g1;
  logic       p1_2, p1_3, p1_4;
  logic       g2_2, g2_3, g2_4, p2_4;
  logic       g3_4;

  assign g0 = A & B;
  assign p0 = A ^ B;

  // cin acts as the generate of bit position 0, so it enters the prefix tree
  // like any other bit and every carry below includes it.
  assign g1[1] = g0[1] | (p0[1] & cin);
  assign g1[2] = g0[2] | (p0[2] & g0[1]);
  assign g1[3] = g0[3] | (p0[3] & g0[2]);
  assign g1[4] = g0[4] | (p0[4] & g0[3]);
  assign p1_2  = p0[2] & p0[1];
  assign p1_3  = p0[3] & p0[2];
  assign p1_4  = p0[4] & p0[3];

  assign g2_2 = g1[2] | (p1_2 & cin);
  assign g2_3 = g1[3] | (p1_3 & g1[1]);
  assign g2_4 = g1[4] | (p1_4 & g1[2]);
  assign p2_4 = p1_4 & p1_2;

  assign g3_4 = g2_4 | (p2_4 & cin);

  assign sum  = p0 ^ {g2_3, g2_2, g1[1], cin};
  assign cout = g3_4;
endmodule

module ks_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:1]   sum,
  output logic             cout
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:1]   sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH:1]   a_q, a_d;
  logic [WIDTH:1]   b_q, b_d;

  logic [WIDTH:1]   a_sh;
  logic [WIDTH:1]   b_sh;
  logic [4:1]       slice_sum;
  logic             slice_cout;
  logic [WIDTH:1]   nib_ext;

  // Shifting by 4*k brings nibble k down to bits [4:1] of the shifted word.
  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  kogge_stone_4bit u_slice (
    .A    (a_sh[4:1]),
    .B    (b_sh[4:1]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    nib_ext = '0;
    nib_ext[4:1] = slice_sum;

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // sum was cleared at start, so OR-ing the nibble in is a plain write.
        sum_d   = sum_q | (nib_ext << {idx_q, 2'b00});
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_ks_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_ks_serial_adder
//   Self-checking bench for ks_serial_adder with NIBBLES = 4. A timeline model
//   (edges elapsed since an accepted start, result from plain addition) is
//   compared with the DUT outputs on every falling edge; directed scenarios
//   add literal expectations.
// ---------------------------------------------------------------------------
module tb_ks_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cin;
  logic [W:1]   a;
  logic [W:1]   b;
  logic         busy;
  logic         done;
  logic [W:1]   sum;
  logic         cout;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // Model: m_n = edges since the accepting edge (-1 when no operation).
  int         m_n = -1;
  logic [W:0] m_res = '0;
  logic [W:1] m_last_sum = '0;
  logic       m_last_cout = 1'b0;
  bit         m_valid = 1'b0;

  ks_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:1] mask_low(input int n);
    logic [W:1] m;
    m = '0;
    for (int i = 1; i <= W; i++) if (i <= 4 * n) m[i] = 1'b1;
    return m;
  endfunction

  // Compare, then advance the model with the inputs the next edge will sample.
  initial begin
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        exp_busy = (m_n >= 0 && m_n < N);
        chk("busy", busy, exp_busy);
        chk("done", done, m_n == N);
        if (exp_busy) begin
          chk("sum_partial", sum, m_res[W-1:0] & mask_low(m_n));
        end else begin
          chk("sum", sum, m_last_sum);
          chk("cout", cout, m_last_cout);
        end
      end
      if (done === 1'b1) done_cnt++;
      if (rst) begin
        m_valid     = 1'b1;
        m_n         = -1;
        m_last_sum  = '0;
        m_last_cout = 1'b0;
      end else if (m_valid) begin
        if (!(m_n >= 0 && m_n < N) && start) begin
          m_n   = 0;
          m_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end else if (m_n >= 0 && m_n < N) begin
          m_n++;
          if (m_n == N) begin
            m_last_sum  = m_res[W-1:0];
            m_last_cout = m_res[W];
          end
        end else begin
          m_n = -1;
        end
      end
    end
  end

  // Pulse start for one edge, then scramble the operand inputs.
  task automatic do_op(input logic [W:1] av, input logic [W:1] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Wait (bounded) for done, check literals, return just after the next edge.
  task automatic wait_done(input string name, input logic [W:1] es, input logic ec,
                           input int exp_bc);
    int  bc;
    bit  got;
    bc  = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) bc++;
    end
    if (!got) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_sum"}, sum, es);
      chk({name, "_cout"}, cout, ec);
      if (exp_bc >= 0) chk({name, "_busy_cycles"}, bc, exp_bc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(16'h0003, 16'h0006, 1'b0);
    wait_done("small", 16'h0009, 1'b0, 4);

    do_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done("ripple", 16'h0000, 1'b1, 4);

    do_op(16'hFFFF, 16'h0000, 1'b1);
    wait_done("cin_ripple", 16'h0000, 1'b1, 4);
    do_op(16'h1234, 16'h4321, 1'b1);
    wait_done("mixed", 16'h5556, 1'b0, 4);

    // start while busy must be ignored
    d0 = done_cnt;
    do_op(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored", 16'h0100, 1'b0, -1);
    repeat (6) @(posedge clk);
    #1;
    chk("ignored_done_pulses", done_cnt - d0, 1);

    // reset after two RUN edges aborts the operation
    do_op(16'h8000, 16'h8000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    // back-to-back: start held high through the DONE cycle
    do_op(16'h1111, 16'h2222, 1'b0);
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    wait_done("b2b_first", 16'h3333, 1'b0, 4);
    start = 1'b0;
    wait_done("b2b_second", 16'h8000, 1'b0, 4);

    // randomized traffic with corner operands and occasional resets
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: a = '1;
        1: a = '0;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = '1;
        1: b = 16'h0001;
        default: b = W'($urandom);
      endcase
      cin   = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 60) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
